// File: rtl/cache_pkg.sv
// Shared FSM state type and geometry helpers for the cache line-transfer engine.
// Supplies default cache geometry (CACHE_T / CACHE_S / CACHE_B) when the build does not set it.
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StRefill    = 2'd2,
        StDone      = 2'd3
    } xfer_state_e;

    localparam int unsigned DefaultOffsetWidth = `CACHE_B;

    // Word-index width for a byte-offset width; kept at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned offset_width);
        return (offset_width > 3) ? offset_width - 2 : 1;
    endfunction

    localparam int unsigned DefaultCntWidth = cnt_width(DefaultOffsetWidth);
    localparam int unsigned DefaultWords    = 2 ** (DefaultOffsetWidth - 2);

endpackage

// File: rtl/word_counter.sv
// Word index (CNT) and completed-transfer count (XFER) for one line burst.
// Load restarts a burst at an arbitrary word; o_last marks the final word of the burst.
module word_counter
    import cache_pkg::*;
#(
    parameter int unsigned CntWidth = DefaultCntWidth,
    parameter int unsigned Words    = DefaultWords
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [CntWidth-1:0] i_load_val,
    input  logic                i_inc,
    output logic [CntWidth-1:0] o_cnt,
    output logic                o_last
);

    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(Words - 1);
    localparam logic [CntWidth:0]   LastXfer = (CntWidth + 1)'(Words - 1);

    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_next;
    logic [CntWidth:0]   r_xfer;
    logic [CntWidth:0]   w_xfer_next;

    always_comb begin
        w_cnt_next  = r_cnt;
        w_xfer_next = r_xfer;
        if (i_load) begin
            w_cnt_next  = i_load_val;
            w_xfer_next = '0;
        end else if (i_inc) begin
            w_cnt_next  = (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
            w_xfer_next = r_xfer + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_xfer <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_xfer <= w_xfer_next;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_xfer == LastXfer);

endmodule

// File: rtl/line_transfer.sv
// Cache miss service: optional dirty-victim writeback, then line refill from main memory.
// Define LINE_TRANSFER_CRITICAL_WORD_FIRST_EN to start the refill at the missing word.
module line_transfer
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = `CACHE_T,
    parameter int unsigned SET_WIDTH    = `CACHE_S,
    parameter int unsigned OFFSET_WIDTH = `CACHE_B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 writeback_i,
    input  logic [31:0]          addr_i,
    input  logic [TAG_WIDTH-1:0] victim_tag_i,
    input  logic [31:0]          line_data_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 fill_we_o,
    output logic [31:0]          fill_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned Words = 2 ** (OFFSET_WIDTH - 2);
    localparam int unsigned CntW  = cnt_width(OFFSET_WIDTH);

    xfer_state_e          r_state;
    xfer_state_e          w_state_next;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [TAG_WIDTH-1:0] r_victim_tag;
    logic [SET_WIDTH-1:0] r_index;
    logic [CntW-1:0]      w_cnt;
    logic [CntW-1:0]      w_cnt_load_val;
    logic [CntW-1:0]      w_refill_start;
    logic                 w_last;
    logic                 w_start;
    logic                 w_complete;
    logic                 w_cnt_load;
    logic                 w_cnt_inc;
    logic                 w_unused_addr;

    assign w_start    = (r_state == StIdle) && start_i;
    assign w_complete = mem_req_o && mem_ready_i;

`ifdef LINE_TRANSFER_CRITICAL_WORD_FIRST_EN
    logic [CntW-1:0] r_crit_word;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_crit_word <= '0;
        end else if (w_start) begin
            r_crit_word <= addr_i[OFFSET_WIDTH-1:2];
        end
    end

    // In IDLE the latch is not loaded yet, so take the critical word straight from addr_i.
    assign w_refill_start = (r_state == StIdle) ? addr_i[OFFSET_WIDTH-1:2] : r_crit_word;
    assign w_unused_addr  = ^addr_i[1:0];
`else
    assign w_refill_start = '0;
    assign w_unused_addr  = ^addr_i[OFFSET_WIDTH-1:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tag        <= '0;
            r_index      <= '0;
            r_victim_tag <= '0;
        end else if (w_start) begin
            r_tag        <= addr_i[OFFSET_WIDTH+SET_WIDTH +: TAG_WIDTH];
            r_index      <= addr_i[OFFSET_WIDTH +: SET_WIDTH];
            r_victim_tag <= victim_tag_i;
        end
    end

    // Writeback always walks the line from word 0; refill may start elsewhere.
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        if (w_start) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = writeback_i ? '0 : w_refill_start;
        end else if ((r_state == StWriteback) && w_complete && w_last) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_refill_start;
        end
    end

    assign w_cnt_inc = w_complete && !w_cnt_load;

    word_counter #(
        .CntWidth (CntW),
        .Words    (Words)
    ) u_word_counter (
        .i_clk      (clk_i),
        .i_rst_n    (rst_i),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_inc      (w_cnt_inc),
        .o_cnt      (w_cnt),
        .o_last     (w_last)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_next = writeback_i ? StWriteback : StRefill;
                end
            end
            StWriteback: begin
                if (w_complete && w_last) begin
                    w_state_next = StRefill;
                end
            end
            StRefill: begin
                if (w_complete && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        fill_we_o   = 1'b0;
        fill_data_o = '0;
        busy_o      = (r_state != StIdle);
        done_o      = 1'b0;
        unique case (r_state)
            StWriteback: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {r_victim_tag, r_index, w_cnt, 2'b00};
                mem_wdata_o = line_data_i;
            end
            StRefill: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {r_tag, r_index, w_cnt, 2'b00};
                fill_we_o   = mem_ready_i;
                fill_data_o = mem_rdata_i;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_transfer.sv
// Self-checking bench for line_transfer: directed misses plus randomized traffic.
// Expected bus activity is derived from the miss address, victim tag and line geometry.
module tb_line_transfer;

    localparam int unsigned T     = 26;
    localparam int unsigned S     = 2;
    localparam int unsigned B     = 4;
    localparam int unsigned WORDS = 1 << (B - 2);

    logic         clk_i        = 1'b0;
    logic         rst_i        = 1'b0;
    logic         start_i      = 1'b0;
    logic         writeback_i  = 1'b0;
    logic [31:0]  addr_i       = '0;
    logic [T-1:0] victim_tag_i = '0;
    logic [31:0]  line_data_i  = '0;
    logic [31:0]  mem_rdata_i  = '0;
    logic         mem_ready_i  = 1'b0;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         fill_we_o;
    logic [31:0]  fill_data_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    line_transfer #(
        .TAG_WIDTH    (T),
        .SET_WIDTH    (S),
        .OFFSET_WIDTH (B)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .writeback_i  (writeback_i),
        .addr_i       (addr_i),
        .victim_tag_i (victim_tag_i),
        .line_data_i  (line_data_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .fill_we_o    (fill_we_o),
        .fill_data_o  (fill_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // First refill word: the missing word in the critical-word-first build, else word 0.
    function automatic int unsigned first_word(input logic [31:0] addr);
`ifdef LINE_TRANSFER_CRITICAL_WORD_FIRST_EN
        return (addr >> 2) % WORDS;
`else
        return (addr == 32'hFFFF_FFFF) ? 0 : 0;
`endif
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] tag, input logic [31:0] idx,
                                              input int unsigned w);
        return (tag << (S + B)) + (idx << B) + (32'(w) << 2);
    endfunction

    task automatic check_idle(input string tag);
        check1({tag, "_busy"}, busy_o, 1'b0);
        check1({tag, "_req"}, mem_req_o, 1'b0);
        check1({tag, "_we"}, mem_we_o, 1'b0);
        check1({tag, "_fill_we"}, fill_we_o, 1'b0);
        check1({tag, "_done"}, done_o, 1'b0);
        check32({tag, "_addr"}, mem_addr_o, 32'h0);
    endtask

    // One whole miss; noise=1 wiggles start_i and the sampled inputs while busy.
    task automatic run_txn(input logic [31:0] addr, input logic wb, input logic [T-1:0] vtag,
                           input int unsigned wait_min, input int unsigned wait_max,
                           input logic noise);
        logic [31:0] exp_addr[$];
        logic        exp_we[$];
        logic [31:0] tag;
        logic [31:0] idx;
        int unsigned fw;
        int unsigned waits;
        logic        rdy;
        tag = addr >> (S + B);
        idx = (addr >> B) % (1 << S);
        fw  = first_word(addr);
        if (wb) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                exp_addr.push_back(word_addr(32'(vtag), idx, i));
                exp_we.push_back(1'b1);
            end
        end
        for (int unsigned i = 0; i < WORDS; i++) begin
            exp_addr.push_back(word_addr(tag, idx, (fw + i) % WORDS));
            exp_we.push_back(1'b0);
        end

        @(posedge clk_i); #1;
        start_i      = 1'b1;
        writeback_i  = wb;
        addr_i       = addr;
        victim_tag_i = vtag;
        mem_ready_i  = 1'($urandom);
        @(negedge clk_i);
        check_idle("start_cycle");

        for (int k = 0; k < exp_addr.size(); k++) begin
            waits = $urandom_range(wait_max, wait_min);
            for (int unsigned w = 0; w <= waits; w++) begin
                @(posedge clk_i); #1;
                start_i = noise ? 1'($urandom) : 1'b0;
                if (noise) begin
                    addr_i       = $urandom;
                    writeback_i  = 1'($urandom);
                    victim_tag_i = T'($urandom);
                end
                rdy         = (w == waits);
                mem_ready_i = rdy;
                line_data_i = $urandom;
                mem_rdata_i = $urandom;
                @(negedge clk_i);
                check1("xfer_busy", busy_o, 1'b1);
                check1("xfer_req", mem_req_o, 1'b1);
                check1("xfer_we", mem_we_o, exp_we[k]);
                check32("xfer_addr", mem_addr_o, exp_addr[k]);
                check1("xfer_fill_we", fill_we_o, rdy && !exp_we[k]);
                check1("xfer_done", done_o, 1'b0);
                if (exp_we[k]) begin
                    check32("wb_wdata", mem_wdata_o, line_data_i);
                end else begin
                    check32("fill_data", fill_data_o, mem_rdata_i);
                end
            end
        end

        @(posedge clk_i); #1;
        start_i     = noise;
        mem_ready_i = 1'($urandom);
        @(negedge clk_i);
        check1("done_pulse", done_o, 1'b1);
        check1("done_busy", busy_o, 1'b1);
        check1("done_req", mem_req_o, 1'b0);
        check1("done_we", mem_we_o, 1'b0);
        check1("done_fill_we", fill_we_o, 1'b0);

        @(posedge clk_i); #1;
        start_i     = 1'b0;
        mem_ready_i = 1'($urandom);
        @(negedge clk_i);
        check_idle("after_done");
    endtask

    initial begin
        logic [31:0] raddr;
        logic [31:0] rtag;
        logic [31:0] ridx;

        #2;
        check_idle("reset");
        check32("reset_wdata", mem_wdata_o, 32'h0);
        check32("reset_fill_data", fill_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        run_txn(32'h0000_0124, 1'b0, T'(0), 0, 0, 1'b0);
        run_txn(32'h0000_0124, 1'b1, T'(1), 0, 0, 1'b0);
        run_txn(32'h0000_0128, 1'b0, T'(0), 0, 0, 1'b0);
        run_txn(32'h0000_0124, 1'b0, T'(0), 3, 3, 1'b0);
        run_txn(32'hABCD_E13C, 1'b1, T'(26'h2AA_AAAA), 3, 3, 1'b0);

        // Reset asserted while the second refill word is on the bus.
        raddr = $urandom;
        rtag  = raddr >> (S + B);
        ridx  = (raddr >> B) % (1 << S);
        @(posedge clk_i); #1;
        start_i     = 1'b1;
        writeback_i = 1'b0;
        addr_i      = raddr;
        mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        #1;
        check32("rst_word2_addr", mem_addr_o,
                word_addr(rtag, ridx, (first_word(raddr) + 1) % WORDS));
        rst_i = 1'b0;
        #1;
        check_idle("rst_mid");
        check32("rst_mid_fill_data", fill_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check_idle("rst_release");

        run_txn(raddr, 1'b0, T'(0), 0, 1, 1'b0);
        run_txn(32'h0000_0134, 1'b1, T'(5), 0, 2, 1'b1);

        for (int n = 0; n < 20; n++) begin
            run_txn($urandom, 1'($urandom), T'($urandom), 0, 2, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
